// File: rtl/ctx_ctrl_pkg.sv
// rtl/ctx_ctrl_pkg.sv - shared types and constants for the register-file context save/restore sequencer
package ctx_ctrl_pkg;

  localparam int WORD_BYTES = 4;
  localparam int RF_ADDR_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_RD,
    ST_SAVE_MEM,
    ST_RESTORE_MEM,
    ST_RESTORE_WR,
    ST_DONE
  } ctx_state_e;

endpackage

// File: rtl/regfile_ctx_switch_ctrl.sv
// rtl/regfile_ctx_switch_ctrl.sv - sequences register-file save to / restore from a memory save area
// Owns the RF read-address and write ports and stalls the pipeline while BUSY.
module regfile_ctx_switch_ctrl
  import ctx_ctrl_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SAVE_REQ,
  input  logic                 RESTORE_REQ,
  input  logic [ADDR_W-1:0]    BASE_ADDR,
  output logic                 BUSY,
  output logic                 PIPE_STALL,
  output logic                 DONE,
  output logic [RF_ADDR_W-1:0] RF_RADDR,
  input  logic [DATA_W-1:0]    RF_RDATA,
  output logic [RF_ADDR_W-1:0] RF_WADDR,
  output logic [DATA_W-1:0]    RF_WDATA,
  output logic                 RF_WRITE,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  output logic [DATA_W-1:0]    MEM_WDATA,
  output logic                 MEM_WRITE,
  output logic                 MEM_READ,
  input  logic [DATA_W-1:0]    MEM_RDATA,
  input  logic                 MEM_BUSYWAIT
);

  localparam logic [RF_ADDR_W-1:0] FIRST_IDX = RF_ADDR_W'(FIRST_REG);
  localparam logic [RF_ADDR_W-1:0] LAST_IDX  = RF_ADDR_W'(LAST_REG);

  ctx_state_e           state, state_nxt;
  logic [RF_ADDR_W-1:0] idx, idx_nxt;
  logic [ADDR_W-1:0]    base, base_nxt;
  logic [ADDR_W-1:0]    addr_sum;
  logic                 last_reg, mem_done, load_addr;
  logic                 done_nxt, mem_write_nxt, mem_read_nxt, rf_write_nxt;
  logic [DATA_W-1:0]    mem_wdata_nxt, rf_wdata_nxt;
  logic [RF_ADDR_W-1:0] rf_raddr_nxt, rf_waddr_nxt;

  assign last_reg = (idx == LAST_IDX);
  assign mem_done = (MEM_WRITE | MEM_READ) & ~MEM_BUSYWAIT;

  // Address of the word for the register being moved into next; index never drops below FIRST_REG.
  assign addr_sum = base_nxt + ADDR_W'(idx_nxt - FIRST_IDX) * ADDR_W'(WORD_BYTES);

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    base_nxt      = base;
    done_nxt      = 1'b0;
    rf_write_nxt  = 1'b0;
    load_addr     = 1'b0;
    mem_write_nxt = MEM_WRITE;
    mem_read_nxt  = MEM_READ;
    mem_wdata_nxt = MEM_WDATA;
    rf_wdata_nxt  = RF_WDATA;
    rf_raddr_nxt  = RF_RADDR;
    rf_waddr_nxt  = RF_WADDR;
    case (state)
      ST_IDLE: begin
        if (SAVE_REQ) begin
          state_nxt    = ST_SAVE_RD;
          base_nxt     = BASE_ADDR;
          idx_nxt      = FIRST_IDX;
          rf_raddr_nxt = FIRST_IDX;
        end else if (RESTORE_REQ) begin
          state_nxt    = ST_RESTORE_MEM;
          base_nxt     = BASE_ADDR;
          idx_nxt      = FIRST_IDX;
          mem_read_nxt = 1'b1;
          load_addr    = 1'b1;
        end
      end
      ST_SAVE_RD: begin
        mem_wdata_nxt = RF_RDATA;
        mem_write_nxt = 1'b1;
        load_addr     = 1'b1;
        state_nxt     = ST_SAVE_MEM;
      end
      ST_SAVE_MEM: begin
        if (mem_done) begin
          mem_write_nxt = 1'b0;
          if (last_reg) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt      = idx + RF_ADDR_W'(1);
            rf_raddr_nxt = idx + RF_ADDR_W'(1);
            state_nxt    = ST_SAVE_RD;
          end
        end
      end
      ST_RESTORE_MEM: begin
        if (mem_done) begin
          rf_wdata_nxt = MEM_RDATA;
          rf_waddr_nxt = idx;
          rf_write_nxt = 1'b1;
          mem_read_nxt = 1'b0;
          state_nxt    = ST_RESTORE_WR;
        end
      end
      ST_RESTORE_WR: begin
        if (last_reg) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt      = idx + RF_ADDR_W'(1);
          mem_read_nxt = 1'b1;
          load_addr    = 1'b1;
          state_nxt    = ST_RESTORE_MEM;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      idx       <= FIRST_IDX;
      base      <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RF_RADDR  <= '0;
      RF_WADDR  <= '0;
      RF_WDATA  <= '0;
      RF_WRITE  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_WRITE <= 1'b0;
      MEM_READ  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      base      <= base_nxt;
      BUSY      <= (state_nxt != ST_IDLE);
      DONE      <= done_nxt;
      RF_RADDR  <= rf_raddr_nxt;
      RF_WADDR  <= rf_waddr_nxt;
      RF_WDATA  <= rf_wdata_nxt;
      RF_WRITE  <= rf_write_nxt;
      MEM_WDATA <= mem_wdata_nxt;
      MEM_WRITE <= mem_write_nxt;
      MEM_READ  <= mem_read_nxt;
      if (load_addr) MEM_ADDR <= addr_sum;
    end
  end

  assign PIPE_STALL = BUSY;

endmodule
